// File: rtl/priority_code_pkg.sv
// ---------------------------------------------------------------------------
// priority_code_pkg
//
// Shared types and helpers for the priority code decoder and the handshake
// blocks built around it.
//
// Contents:
//   state_t    - decoder state encoding (IDLE / DRIVE / RELEASE)
//   IDX_W_DEF  - default width of an encoded line index
//   N_DEF      - default number of one-hot lines (2**IDX_W_DEF)
//   onehot()   - turns an encoded index into an N_DEF-bit one-hot vector
// ---------------------------------------------------------------------------
package priority_code_pkg;

  localparam int IDX_W_DEF = 2;
  localparam int N_DEF     = 4;

  // IDLE waits for a code, DRIVE holds the request line high until the
  // target answers or the hold window runs out, and RELEASE guarantees the
  // target sees the line low for a cycle before the next request can start.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Every code is legal, so the result always has exactly one bit set.
  function automatic logic [N_DEF-1:0] onehot(input logic [IDX_W_DEF-1:0] idx);
    logic [N_DEF-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/priority_code_decoder_hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer
//
// Small up-counter used to bound how long a handshake waits for its partner.
// It is loaded to zero when a wait starts, counts while enabled, and raises
// expire while the count sits at HOLD_MAX-1 so the owner can give up on that
// cycle. Once expired it stops counting, so it can never wrap.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset, clears the count
//   load    in   restart the wait (count <= 0), has priority over enable
//   enable  in   advance the count by one this cycle
//   expire  out  count has reached HOLD_MAX-1
// ---------------------------------------------------------------------------
module hold_timer #(
  parameter int CNT_W    = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  // Reject parameter sets where the last count does not fit the counter or
  // the hold window is outside the supported range.
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("hold_timer: HOLD_MAX must be in 1..255");
  end
  if (HOLD_MAX >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("hold_timer: HOLD_MAX must be below 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] count;

  // The counter restarts on load and otherwise climbs while enabled. It
  // freezes at the expiry value so a late or missing owner reaction cannot
  // push it past the range the comparator is looking at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

  // Expiry is a plain compare on the registered count. The owner decides
  // what to do with it on the same cycle.
  assign expire = (count == LAST_COUNT);

endmodule

// File: rtl/priority_code_decoder.sv
// ---------------------------------------------------------------------------
// priority_code_decoder
//
// Inverse of the 4-to-2 priority encoder. It accepts a 2-bit code through a
// valid/ready front end and turns it into a one-hot request line. That line
// stays high until the addressed target acknowledges it or the hold window
// expires. Only one transaction is in flight at a time.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   in_valid  in   a code is presented on in_idx
//   in_idx    in   encoded index, code k selects line k
//   in_ready  out  block can accept a code this cycle
//   out_req   out  registered one-hot request, zero when idle
//   out_ack   in   per-line acknowledge from the targets
//   done      out  one-cycle pulse, addressed line acknowledged
//   timeout   out  one-cycle pulse, hold window expired without an ack
//   spur_ack  out  one-cycle pulse, ack seen on a line not being driven
//   busy      out  a transaction is in flight
//
// All outputs are flops. Nothing from out_ack reaches out_req without
// passing through a register.
// ---------------------------------------------------------------------------
module priority_code_decoder
  import priority_code_pkg::*;
#(
  parameter int IDX_W    = IDX_W_DEF,
  parameter int N        = N_DEF,
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             in_ready,
  output logic [N-1:0]     out_req,
  input  logic [N-1:0]     out_ack,
  output logic             done,
  output logic             timeout,
  output logic             spur_ack,
  output logic             busy
);

  // The decode relies on the index covering the lines exactly. Otherwise
  // some codes would address lines that do not exist.
  if (N != (2 ** IDX_W)) begin : g_bad_n
    $error("priority_code_decoder: N must equal 2**IDX_W");
  end

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     line_mask;
  logic             accept;
  logic             ack_hit;
  logic             spur_hit;
  logic             expire;
  logic             timer_load;
  logic             timer_en;

  logic [N-1:0]     req_d;
  logic             done_d;
  logic             timeout_d;
  logic             spur_d;
  logic             ready_d;
  logic             busy_d;

  // A handshake completes only in IDLE. in_ready is itself a flop that is
  // high exactly when the state is IDLE, so the two always agree.
  assign accept = (state_q == IDLE) && in_valid && in_ready;

  // Decode the captured index into a mask of the line being driven. The
  // mask splits the incoming acks into the one we are waiting for and any
  // that arrive on lines we are not driving.
  always_comb begin
    line_mask        = '0;
    line_mask[idx_q] = 1'b1;
  end

  assign ack_hit  = |(out_ack & line_mask);
  assign spur_hit = |(out_ack & ~line_mask);

  // The hold window starts fresh on every accepted code. It only counts
  // while the request line is actually being driven.
  assign timer_load = accept;
  assign timer_en   = (state_q == DRIVE);

  hold_timer #(
    .CNT_W    (CNT_W),
    .HOLD_MAX (HOLD_MAX)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .enable (timer_en),
    .expire (expire)
  );

  // State register together with the registered outputs. Reset clears
  // everything at once without waiting for a clock, so a request dropped by
  // reset never produces a done or timeout pulse. in_ready comes out of
  // reset high, so a code can be taken on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      out_req  <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      spur_ack <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      out_req  <= req_d;
      done     <= done_d;
      timeout  <= timeout_d;
      spur_ack <= spur_d;
      busy     <= busy_d;
      in_ready <= ready_d;
    end
  end

  // The captured index only changes when a new code is accepted. It keeps
  // pointing at the driven line for the whole of DRIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= in_idx;
    end
  end

  // Next-state logic. In DRIVE an ack on the addressed line is checked
  // before expiry, so an ack that lands on the last allowed cycle still
  // counts as success. RELEASE always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (ack_hit) begin
          state_d = RELEASE;
        end else if (expire) begin
          state_d = IDLE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic. It computes the values the output flops take at the next
  // edge. The request rises the cycle after accept. It falls on the same
  // edge that raises done or timeout, so each pulse lines up with the drop.
  // Spurious acks are only looked at while driving. They are reported even
  // on the cycle the real ack arrives.
  always_comb begin
    req_d     = '0;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    spur_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_d[in_idx] = 1'b1;
        end
      end
      DRIVE: begin
        spur_d = spur_hit;
        if (ack_hit) begin
          done_d = 1'b1;
        end else if (expire) begin
          timeout_d = 1'b1;
        end else begin
          req_d = line_mask;
        end
      end
      RELEASE: begin
        req_d = '0;
      end
      default: begin
        req_d = '0;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

endmodule

// File: tb/tb_priority_code_decoder.sv
// ---------------------------------------------------------------------------
// tb_priority_code_decoder
//
// Self-checking bench for priority_code_decoder. Each accepted code pushes
// its expected outcome (line and done/timeout) onto a scoreboard queue. A
// negedge monitor pops the queue whenever done or timeout fires and checks
// the pulse kind and the line that was driven. Directed sequences check
// reset, the ack path, timeout, the ack/timeout collision, spurious acks,
// mid-flight reset and a back-to-back sweep of all codes.
// ---------------------------------------------------------------------------
module tb_priority_code_decoder;

  localparam int IDX_W    = 2;
  localparam int N        = 4;
  localparam int HOLD_MAX = 15;
  localparam int CNT_W    = 8;
  localparam int CLK_HALF = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [IDX_W-1:0] in_idx;
  logic             in_ready;
  logic [N-1:0]     out_req;
  logic [N-1:0]     out_ack;
  logic             done;
  logic             timeout;
  logic             spur_ack;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [IDX_W-1:0] idx;
    bit               want_done;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [N-1:0] prev_req = '0;

  priority_code_decoder #(
    .IDX_W    (IDX_W),
    .N        (N),
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_idx   (in_idx),
    .in_ready (in_ready),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .done     (done),
    .timeout  (timeout),
    .spur_ack (spur_ack),
    .busy     (busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #CLK_HALF clk = ~clk;
  end

  // Independent one-hot model of a code
  function automatic logic [N-1:0] line_of(input logic [IDX_W-1:0] idx);
    logic [N-1:0] one;
    one = 1;
    return one << idx;
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [IDX_W-1:0] idx,
                               input logic [N-1:0] ack);
    in_valid = v;
    in_idx   = idx;
    out_ack  = ack;
  endtask

  // Present a code once in_ready is seen (bounded wait), record its
  // expected outcome, and check the request appears one cycle later
  task automatic sendCode(input logic [IDX_W-1:0] idx, input bit want_done);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_wait", 32'(in_ready), 1);
    applyStimulus(1'b1, idx, '0);
    sb.push_back('{idx, want_done});
    @(negedge clk);
    applyStimulus(1'b0, idx, '0);
    checkOutput("accept_req", 32'(out_req), 32'(line_of(idx)));
    checkOutput("accept_busy", 32'(busy), 1);
    checkOutput("accept_ready", 32'(in_ready), 0);
  endtask

  // Ack the given line and check the RELEASE cycle that follows
  task automatic ackLine(input logic [IDX_W-1:0] idx);
    out_ack = line_of(idx);
    @(negedge clk);
    out_ack = '0;
    checkOutput("ack_req_clear", 32'(out_req), 0);
    checkOutput("ack_done", 32'(done), 1);
    checkOutput("ack_no_timeout", 32'(timeout), 0);
    checkOutput("release_ready", 32'(in_ready), 0);
    checkOutput("release_busy", 32'(busy), 1);
  endtask

  // Scoreboard monitor: never multi-hot, and every done/timeout pulse must
  // match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("never_multihot", 32'($onehot0(out_req)), 1);
      if (done || timeout) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_pulse", 32'({done, timeout}), 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("sb_done", 32'(done), 32'(mon_e.want_done));
          checkOutput("sb_timeout", 32'(timeout), mon_e.want_done ? 0 : 1);
          checkOutput("sb_line", 32'(prev_req), 32'(line_of(mon_e.idx)));
        end
      end
      prev_req <= out_req;
    end else begin
      prev_req <= '0;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequences
  initial begin
    int       hi;
    longint   t_prev;
    longint   t_now;

    rst = 1'b0;
    applyStimulus(1'b0, '0, '0);

    // Reset asserted mid-cycle: outputs clear before any clock edge
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_req", 32'(out_req), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_timeout", 32'(timeout), 0);
    checkOutput("rst_spur", 32'(spur_ack), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 32'(in_ready), 1);
    checkOutput("rst_idle_busy", 32'(busy), 0);

    // Reset and accept: code 2 gives 0100 one cycle later
    $display("[TB] reset and accept");
    sendCode(2'd2, 1'b1);
    ackLine(2'd2);
    @(negedge clk);
    checkOutput("idle_ready_1", 32'(in_ready), 1);

    // Ack path on line 3; an in_valid held during DRIVE is ignored
    $display("[TB] ack path");
    sendCode(2'd3, 1'b1);
    applyStimulus(1'b1, 2'd0, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("hold_req", 32'(out_req), 32'b1000);
    end
    ackLine(2'd3);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("done_single", 32'(done), 0);
    checkOutput("ack_idle_ready", 32'(in_ready), 1);
    checkOutput("no_buffered_accept", 32'(busy), 0);

    // Timeout on line 0: request held exactly HOLD_MAX cycles
    $display("[TB] timeout");
    sendCode(2'd0, 1'b0);
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_req != 4'b0001) break;
      hi++;
    end
    checkOutput("timeout_hold_cycles", 32'(hi), HOLD_MAX);
    checkOutput("timeout_pulse", 32'(timeout), 1);
    checkOutput("timeout_no_done", 32'(done), 0);
    checkOutput("timeout_req_clear", 32'(out_req), 0);
    @(negedge clk);
    checkOutput("timeout_single", 32'(timeout), 0);
    checkOutput("timeout_ready", 32'(in_ready), 1);

    // Ack arriving on the last hold cycle wins over timeout
    $display("[TB] ack/timeout collision");
    sendCode(2'd0, 1'b1);
    repeat (HOLD_MAX - 1) @(negedge clk);
    checkOutput("collide_pre_req", 32'(out_req), 32'b0001);
    ackLine(2'd0);
    @(negedge clk);
    checkOutput("collide_after_timeout", 32'(timeout), 0);
    checkOutput("collide_ready", 32'(in_ready), 1);

    // Spurious ack, then reset mid-flight
    $display("[TB] spurious ack and mid-flight reset");
    sendCode(2'd1, 1'b1);
    out_ack = 4'b0100;
    @(negedge clk);
    out_ack = '0;
    checkOutput("spur_pulse", 32'(spur_ack), 1);
    checkOutput("spur_req_held", 32'(out_req), 32'b0010);
    checkOutput("spur_no_done", 32'(done), 0);
    @(negedge clk);
    checkOutput("spur_single", 32'(spur_ack), 0);
    checkOutput("spur_req_still", 32'(out_req), 32'b0010);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_req", 32'(out_req), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_pulses", 32'({done, timeout, spur_ack}), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("post_rst_quiet", 32'({done, timeout, out_req}), 0);
    end
    checkOutput("post_rst_ready", 32'(in_ready), 1);

    // Sweep all codes back-to-back with immediate acks
    $display("[TB] all codes sweep");
    t_prev = 0;
    for (int i = 0; i < N; i++) begin
      sendCode(IDX_W'(i), 1'b1);
      t_now = $time;
      if (i > 0) begin
        checkOutput("sweep_spacing", 32'((t_now - t_prev) / (2 * CLK_HALF)), 3);
      end
      t_prev = t_now;
      ackLine(IDX_W'(i));
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("sb_drain", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
